// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Widest operand the helper below can take; operands are sign-extended to it.
   localparam int MAX_W = 64;

   // Magnitude of x when it is a signed operand, x unchanged otherwise.
   function automatic logic [MAX_W-1:0] abs_val(input logic sign,
                                                input logic signed [MAX_W-1:0] x);
      return (sign && x[MAX_W-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: operand magnitude latch, shift registers, accumulator, final negate.
// Optional MULT_EARLY_OUT_EN exposes a zero-detect on the unshifted multiplier bits.
module mult_seq_dp
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               last,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef MULT_EARLY_OUT_EN
   output logic               rest_zero,
`endif
   output logic [2*WIDTH-1:0] z
);

   logic signed [MAX_W-1:0] a_ext;
   logic signed [MAX_W-1:0] b_ext;
   logic [WIDTH-1:0]        mag_a;
   logic [WIDTH-1:0]        mag_b;
   logic [WIDTH-1:0]        mplier;
   logic [2*WIDTH-1:0]      mcand;
   logic [2*WIDTH-1:0]      acc;
   logic [2*WIDTH-1:0]      sum;
   logic                    neg;

   always_comb begin
      a_ext = MAX_W'($signed(a));
      b_ext = MAX_W'($signed(b));
      mag_a = WIDTH'(abs_val(sign, a_ext));
      mag_b = WIDTH'(abs_val(sign, b_ext));
      sum   = acc + (mplier[0] ? mcand : '0);
   end

`ifdef MULT_EARLY_OUT_EN
   // Bits above the one being consumed this edge; all zero means nothing left to add.
   assign rest_zero = (mplier[WIDTH-1:1] == '0);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         z      <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         acc    <= '0;
         neg    <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (step) begin
         acc    <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (last)
            z <= neg ? -sum : sum;
      end
   end

endmodule

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier top: start/busy/done FSM and bit counter.
// Define MULT_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are zero.
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             step;
   logic             last;
`ifdef MULT_EARLY_OUT_EN
   logic             rest_zero;
`endif

   always_comb begin
      accept = start && (state != BUSY);
      step   = (state == BUSY);
`ifdef MULT_EARLY_OUT_EN
      last   = step && ((cnt == CNT_LAST) || rest_zero);
`else
      last   = step && (cnt == CNT_LAST);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done <= 1'b0;
               if (start) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .step      (step),
      .last      (last),
      .sign      (sign),
      .a         (a),
      .b         (b),
`ifdef MULT_EARLY_OUT_EN
      .rest_zero (rest_zero),
`endif
      .z         (z)
   );

endmodule
